fwd_hazard_ctrl: RTL and testbench

Forwarding and hazard controller for the 5-stage RV32I pipeline. It keeps its own shadow copy of destination-register information for the ID/EX, EX/MEM and MEM/WB stages and drives the two operand-forwarding 3:1 mux selects in EX. It also generates load-use stalls, branch/jump flushes and data-memory freeze, and keeps saturating stall/flush event counters for debug.

---
 rtl/rv_pkg.sv | 31 +++
 rtl/fwd_sel_unit.sv | 30 +++
 rtl/fwd_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared types for the RV32I pipeline control blocks.
//   fwd_sel_e    : EX operand mux select (register file / MEM/WB / EX/MEM).
//   stage_info_t : everything the hazard logic remembers about the
//                  instruction sitting in ID/EX.
//   dst_info_t   : the destination-only subset kept for EX/MEM and MEM/WB.
package rv_pkg;

    localparam int RV_REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic [RV_REG_AW-1:0] rd;
        logic                 we;
        logic                 memread;
        logic [RV_REG_AW-1:0] rs1;
        logic [RV_REG_AW-1:0] rs2;
    } stage_info_t;

    typedef struct packed {
        logic                 valid;
        logic [RV_REG_AW-1:0] rd;
        logic                 we;
    } dst_info_t;

endpackage

// File: rtl/fwd_sel_unit.sv
// Per-operand forwarding comparator.
//   i_en    : the EX stage holds a real instruction
//   i_rs    : source register of that instruction
//   i_exmem : destination info one stage ahead (highest priority)
//   i_memwb : destination info two stages ahead
//   o_sel   : operand mux select
// There is no handshake here: purely combinational.
module fwd_sel_unit
    import rv_pkg::*;
(
    input  logic                 i_en,
    input  logic [RV_REG_AW-1:0] i_rs,
    input  dst_info_t            i_exmem,
    input  dst_info_t            i_memwb,
    output fwd_sel_e             o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        // x0 is hard-wired zero, so a producer targeting x0 never forwards.
        if (i_en && i_exmem.valid && i_exmem.we &&
            (i_exmem.rd != '0) && (i_exmem.rd == i_rs)) begin
            o_sel = FWD_MEM;
        end else if (i_en && i_memwb.valid && i_memwb.we &&
                     (i_memwb.rd != '0) && (i_memwb.rd == i_rs)) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage RV32I pipeline.
// Keeps shadow copies of ID/EX, EX/MEM and MEM/WB destination info,
// drives the EX forwarding selects, and produces load-use stalls,
// redirect flushes and the data-memory freeze. Two saturating debug
// counters track stall and flush events.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_id_valid/rs1/rs2/rd/regwrite/memread   instruction currently in ID
//   i_ex_redirect                     taken branch/jump resolved in EX
//   i_mem_stall                       data memory busy, freeze everything
//   o_fwd_a_sel, o_fwd_b_sel          EX operand mux selects
//   o_stall_if, o_stall_id            hold PC and IF/ID
//   o_flush_id, o_flush_ex            clear IF/ID, bubble ID/EX
//   o_stall_cnt, o_flush_cnt          saturating event counters
// No valid/ready handshakes: all control outputs are combinational and
// take effect in the cycle they are asserted.
module fwd_hazard_ctrl
    import rv_pkg::*;
#(
    parameter int REG_AW = RV_REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic              i_id_regwrite,
    input  logic              i_id_memread,
    input  logic              i_ex_redirect,
    input  logic              i_mem_stall,
    output logic [1:0]        o_fwd_a_sel,
    output logic [1:0]        o_fwd_b_sel,
    output logic              o_stall_if,
    output logic              o_stall_id,
    output logic              o_flush_id,
    output logic              o_flush_ex,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    stage_info_t      idex_q, idex_d;
    dst_info_t        exmem_q, exmem_d;
    dst_info_t        memwb_q, memwb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             stall_evt;
    logic             flush_evt;
    fwd_sel_e         sel_a;
    fwd_sel_e         sel_b;

    fwd_sel_unit u_fwd_a (
        .i_en    (idex_q.valid),
        .i_rs    (idex_q.rs1),
        .i_exmem (exmem_q),
        .i_memwb (memwb_q),
        .o_sel   (sel_a)
    );

    fwd_sel_unit u_fwd_b (
        .i_en    (idex_q.valid),
        .i_rs    (idex_q.rs2),
        .i_exmem (exmem_q),
        .i_memwb (memwb_q),
        .o_sel   (sel_b)
    );

    assign o_fwd_a_sel = sel_a;
    assign o_fwd_b_sel = sel_b;
    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

    // Both source fields are compared even if the ID instruction ignores
    // one of them; the occasional false stall is cheaper than decoding.
    assign load_use = i_id_valid && idex_q.valid && idex_q.memread &&
                      (idex_q.rd != '0) &&
                      ((idex_q.rd == i_id_rs1) || (idex_q.rd == i_id_rs2));

    // A memory freeze counts as a stall cycle; a load-use only counts when
    // a redirect is not already throwing the ID instruction away.
    assign stall_evt = i_mem_stall || (load_use && !i_ex_redirect);
    assign flush_evt = i_ex_redirect && !i_mem_stall;

    always_comb begin
        o_stall_if  = 1'b0;
        o_stall_id  = 1'b0;
        o_flush_id  = 1'b0;
        o_flush_ex  = 1'b0;
        idex_d      = idex_q;
        exmem_d     = exmem_q;
        memwb_d     = memwb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (i_mem_stall) begin
            // Freeze: shadows hold, redirect and load-use wait for release.
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
        end else begin
            if (i_ex_redirect) begin
                o_flush_id = 1'b1;
                o_flush_ex = 1'b1;
            end else if (load_use) begin
                o_stall_if = 1'b1;
                o_stall_id = 1'b1;
                o_flush_ex = 1'b1;
            end

            if (i_ex_redirect || load_use) begin
                idex_d = '0;
            end else begin
                idex_d = '{valid:   i_id_valid,
                           rd:      i_id_rd,
                           we:      i_id_regwrite,
                           memread: i_id_memread,
                           rs1:     i_id_rs1,
                           rs2:     i_id_rs2};
            end
            exmem_d = '{valid: idex_q.valid, rd: idex_q.rd, we: idex_q.we};
            memwb_d = exmem_q;
        end

        if (stall_evt && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_evt && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed instruction sequences, an
// instruction-level pipeline model compared every cycle, and literal
// expectations at the key points of each scenario.
module tb_fwd_hazard_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic        id_valid;
    logic [4:0]  rs1, rs2, rd;
    logic        we, mr, redir, mstall;
    logic [1:0]  fwd_a, fwd_b;
    logic        stall_if, stall_id, flush_id, flush_ex;
    logic [15:0] stall_cnt, flush_cnt;

    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_id_valid    (id_valid),
        .i_id_rs1      (rs1),
        .i_id_rs2      (rs2),
        .i_id_rd       (rd),
        .i_id_regwrite (we),
        .i_id_memread  (mr),
        .i_ex_redirect (redir),
        .i_mem_stall   (mstall),
        .o_fwd_a_sel   (fwd_a),
        .o_fwd_b_sel   (fwd_b),
        .o_stall_if    (stall_if),
        .o_stall_id    (stall_id),
        .o_flush_id    (flush_id),
        .o_flush_ex    (flush_ex),
        .o_stall_cnt   (stall_cnt),
        .o_flush_cnt   (flush_cnt)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    // pipe[0] is the instruction in EX, pipe[1] one ahead, pipe[2] two ahead.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic       mr;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ins_t;

    ins_t        pipe [3];
    logic [15:0] m_stall_cnt;
    logic [15:0] m_flush_cnt;
    bit          model_ok = 0;

    // ID instruction reads a register the load in EX has not produced yet.
    function automatic logic m_load_use();
        return id_valid && pipe[0].v && pipe[0].mr && (pipe[0].rd != 5'd0) &&
               ((pipe[0].rd == rs1) || (pipe[0].rd == rs2));
    endfunction

    // Nearest in-flight producer wins: distance 1 -> EX/MEM, distance 2 -> MEM/WB.
    function automatic logic [1:0] m_sel(input logic [4:0] src);
        if (!pipe[0].v) return 2'b00;
        for (int d = 1; d <= 2; d++) begin
            if (pipe[d].v && pipe[d].we && (pipe[d].rd != 5'd0) && (pipe[d].rd == src))
                return (d == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        logic lu;
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = '0;
            m_stall_cnt = '0;
            m_flush_cnt = '0;
            model_ok    = 1;
        end else if (mstall) begin
            if (m_stall_cnt != 16'hFFFF) m_stall_cnt = m_stall_cnt + 16'd1;
        end else begin
            lu = m_load_use();
            if (lu && !redir && m_stall_cnt != 16'hFFFF) m_stall_cnt = m_stall_cnt + 16'd1;
            if (redir && m_flush_cnt != 16'hFFFF) m_flush_cnt = m_flush_cnt + 16'd1;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (redir || lu) pipe[0] = '0;
            else pipe[0] = {id_valid, rd, we, mr, rs1, rs2};
        end
    end

    // Every-cycle comparison, mid-cycle, away from the active edge.
    always @(negedge clk) begin
        logic lu, e_stall, e_fid, e_fex;
        if (model_ok && !rst) begin
            lu      = m_load_use();
            e_stall = mstall || (!redir && lu);
            e_fid   = !mstall && redir;
            e_fex   = !mstall && (redir || lu);
            chk("cyc_fwd_a",     32'(fwd_a),     32'(m_sel(pipe[0].rs1)));
            chk("cyc_fwd_b",     32'(fwd_b),     32'(m_sel(pipe[0].rs2)));
            chk("cyc_stall_if",  32'(stall_if),  32'(e_stall));
            chk("cyc_stall_id",  32'(stall_id),  32'(e_stall));
            chk("cyc_flush_id",  32'(flush_id),  32'(e_fid));
            chk("cyc_flush_ex",  32'(flush_ex),  32'(e_fex));
            chk("cyc_stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
            chk("cyc_flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic w, input logic m,
                         input logic rdr, input logic ms);
        id_valid = v; rd = d; rs1 = s1; rs2 = s2; we = w; mr = m;
        redir = rdr; mstall = ms;
        #2;
    endtask

    task automatic bubble();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (3) begin
            bubble();
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bubble();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        do_reset();
        bubble();
        chk("rst_fwd_a",     32'(fwd_a),     32'd0);
        chk("rst_fwd_b",     32'(fwd_b),     32'd0);
        chk("rst_stall_if",  32'(stall_if),  32'd0);
        chk("rst_flush_ex",  32'(flush_ex),  32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        tick();

        // RAW distance 1: add x5 ; sub x6, x5, x4
        drive(1, 5'd5, 5'd1, 5'd2, 1, 0, 0, 0); tick();
        drive(1, 5'd6, 5'd5, 5'd4, 1, 0, 0, 0); tick();
        bubble();
        chk("raw1_a", 32'(fwd_a), 32'b10);
        chk("raw1_b", 32'(fwd_b), 32'b00);
        tick();
        drain();

        // RAW distance 2: wr x9 ; wr x7 ; rd x9, x7
        drive(1, 5'd9,  5'd1, 5'd2, 1, 0, 0, 0); tick();
        drive(1, 5'd7,  5'd1, 5'd2, 1, 0, 0, 0); tick();
        drive(1, 5'd10, 5'd9, 5'd7, 1, 0, 0, 0); tick();
        bubble();
        chk("raw2_a", 32'(fwd_a), 32'b01);
        chk("raw2_b", 32'(fwd_b), 32'b10);
        tick();
        drain();

        // Double write of x7: the nearer producer wins.
        drive(1, 5'd7,  5'd1, 5'd2, 1, 0, 0, 0); tick();
        drive(1, 5'd7,  5'd3, 5'd4, 1, 0, 0, 0); tick();
        drive(1, 5'd11, 5'd7, 5'd0, 1, 0, 0, 0); tick();
        bubble();
        chk("dbl_a", 32'(fwd_a), 32'b10);
        chk("dbl_b", 32'(fwd_b), 32'b00);
        tick();
        drain();

        // Load-use: lw x3 ; add x4, x1, x3
        drive(1, 5'd3, 5'd1, 5'd2, 1, 1, 0, 0); tick();
        drive(1, 5'd4, 5'd1, 5'd3, 1, 0, 0, 0);
        chk("lu_stall_if", 32'(stall_if), 32'd1);
        chk("lu_stall_id", 32'(stall_id), 32'd1);
        chk("lu_flush_ex", 32'(flush_ex), 32'd1);
        chk("lu_flush_id", 32'(flush_id), 32'd0);
        tick();
        drive(1, 5'd4, 5'd1, 5'd3, 1, 0, 0, 0);
        chk("lu_re_stall", 32'(stall_if), 32'd0);
        chk("lu_re_flush", 32'(flush_ex), 32'd0);
        tick();
        bubble();
        chk("lu_fwd_b",     32'(fwd_b),     32'b01);
        chk("lu_fwd_a",     32'(fwd_a),     32'b00);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        tick();
        drain();

        // Load into x0 followed by a reader of x0: no hazard, no forwarding.
        drive(1, 5'd0, 5'd1, 5'd2, 1, 1, 0, 0); tick();
        drive(1, 5'd5, 5'd0, 5'd0, 1, 0, 0, 0);
        chk("x0_stall", 32'(stall_if), 32'd0);
        chk("x0_flush", 32'(flush_ex), 32'd0);
        tick();
        bubble();
        chk("x0_fwd_a", 32'(fwd_a), 32'b00);
        chk("x0_fwd_b", 32'(fwd_b), 32'b00);
        tick();
        drain();

        // Redirect coinciding with a load-use condition.
        do_reset();
        drive(1, 5'd3, 5'd1, 5'd2, 1, 1, 0, 0); tick();
        drive(1, 5'd4, 5'd1, 5'd3, 1, 0, 1, 0);
        chk("rdl_flush_id", 32'(flush_id), 32'd1);
        chk("rdl_flush_ex", 32'(flush_ex), 32'd1);
        chk("rdl_stall_if", 32'(stall_if), 32'd0);
        chk("rdl_stall_id", 32'(stall_id), 32'd0);
        tick();
        bubble();
        chk("rdl_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("rdl_stall_cnt", 32'(stall_cnt), 32'd0);
        tick();
        drain();

        // Memory freeze with redirect pending and a forwarding pair in flight.
        do_reset();
        drive(1, 5'd5, 5'd1, 5'd2, 1, 0, 0, 0); tick();
        drive(1, 5'd8, 5'd5, 5'd6, 1, 0, 0, 0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
            chk("ms_fwd_a",    32'(fwd_a),    32'b10);
            chk("ms_fwd_b",    32'(fwd_b),    32'b00);
            chk("ms_stall_if", 32'(stall_if), 32'd1);
            chk("ms_flush_id", 32'(flush_id), 32'd0);
            chk("ms_flush_ex", 32'(flush_ex), 32'd0);
            tick();
        end
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        chk("ms_rel_flush_id", 32'(flush_id),  32'd1);
        chk("ms_rel_flush_ex", 32'(flush_ex),  32'd1);
        chk("ms_rel_stall_if", 32'(stall_if),  32'd0);
        chk("ms_stall_cnt",    32'(stall_cnt), 32'd3);
        chk("ms_rel_fwd_a",    32'(fwd_a),     32'b10);
        tick();
        bubble();
        chk("ms_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("ms_post_flush", 32'(flush_id), 32'd0);
        tick();

        // Reset in the middle of a memory freeze.
        drive(1, 5'd5, 5'd1, 5'd2, 1, 0, 0, 0); tick();
        drive(1, 5'd9, 5'd5, 5'd5, 1, 0, 0, 0); tick();
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1); tick();
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1); tick();
        rst = 1'b1;
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
        tick();
        rst = 1'b0;
        bubble();
        chk("mrst_fwd_a",     32'(fwd_a),     32'd0);
        chk("mrst_fwd_b",     32'(fwd_b),     32'd0);
        chk("mrst_stall_if",  32'(stall_if),  32'd0);
        chk("mrst_stall_id",  32'(stall_id),  32'd0);
        chk("mrst_flush_id",  32'(flush_id),  32'd0);
        chk("mrst_flush_ex",  32'(flush_ex),  32'd0);
        chk("mrst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("mrst_flush_cnt", 32'(flush_cnt), 32'd0);
        tick();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
